vram_scheduler: RTL and testbench

VRAM_SCHEDULER -- requirements
Module: vram_scheduler

---
 rtl/vram_sched_pkg.sv | 21 ++
 rtl/vram_phase_ctr.sv | 26 ++
 rtl/vram_scheduler.sv | 144 ++++++++++++++
 tb/tb_vram_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_sched_pkg.sv
// Shared types and phase constants for the VRAM CPU/video scheduler.
package vram_sched_pkg;

    localparam int unsigned PHASE_W = 3;

    localparam logic [PHASE_W-1:0] VID_SLOT_FIRST = PHASE_W'(5);
    localparam logic [PHASE_W-1:0] VID_SLOT_LAST  = PHASE_W'(6);
    localparam logic [PHASE_W-1:0] LOAD_PHASE     = PHASE_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } cpu_state_t;

    // A CPU access may start only when it cannot collide with the next video fetch.
    function automatic logic cpu_slot_free(input logic [PHASE_W-1:0] phase, input logic hblank);
        return hblank || (phase <= PHASE_W'(3)) || (phase == LOAD_PHASE);
    endfunction

endpackage

// File: rtl/vram_phase_ctr.sv
// 3-bit pixel phase counter: advances on pix_en, held at 0 during horizontal blank.
module vram_phase_ctr
    import vram_sched_pkg::*;
(
    input  logic               clk,
    input  logic               n_clr,
    input  logic               pix_en,
    input  logic               hblank,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] r_phase;

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            r_phase <= '0;
        end else if (hblank) begin
            r_phase <= '0;
        end else if (pix_en) begin
            r_phase <= r_phase + PHASE_W'(1);
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/vram_scheduler.sv
// Arbitrates one synchronous VRAM port between the tile fetch and a stalling CPU.
// Optional sticky protocol-error flag cpu_err when VRAM_SCHED_ERR_EN is defined.
module vram_scheduler
    import vram_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_clr,
    input  logic              pix_en,
    input  logic              hblank,
    input  logic [ADDR_W-1:0] tile_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tile_code,
    output logic              sr_load_n
`ifdef VRAM_SCHED_ERR_EN
    ,
    output logic              cpu_err
`endif
);

    logic [PHASE_W-1:0] w_phase;
    logic               w_vid_slot;
    logic               w_grant;
    logic               w_rd_ack;
    cpu_state_t         r_state;
    cpu_state_t         w_state_nxt;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_tile_code;

    vram_phase_ctr u_phase_ctr (
        .clk    (clk),
        .n_clr  (n_clr),
        .pix_en (pix_en),
        .hblank (hblank),
        .phase  (w_phase)
    );

    assign w_vid_slot = !hblank && (w_phase >= VID_SLOT_FIRST) && (w_phase <= VID_SLOT_LAST);
    assign w_grant    = cpu_req && cpu_slot_free(w_phase, hblank);

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM port mux; the write strobe is killed by reset in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        ram_addr    = tile_addr;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_ACK;
                if (!w_vid_slot) begin
                    ram_addr  = cpu_addr;
                    ram_we    = cpu_we && n_clr;
                    ram_wdata = cpu_wdata;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_rd_ack = (r_state == ST_ACK) && !cpu_we;

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            r_rdata     <= '0;
            r_tile_code <= '0;
        end else begin
            if (w_rd_ack) begin
                r_rdata <= ram_rdata;
            end
            if ((w_phase == VID_SLOT_LAST) && pix_en) begin
                r_tile_code <= ram_rdata;
            end
        end
    end

    // Read data is bypassed during the ack cycle and held in r_rdata afterwards.
    assign cpu_ack   = (r_state == ST_ACK);
    assign cpu_wait  = cpu_req && !cpu_ack;
    assign cpu_rdata = w_rd_ack ? ram_rdata : r_rdata;
    assign tile_code = r_tile_code;
    assign sr_load_n = !(n_clr && pix_en && !hblank && (w_phase == LOAD_PHASE));

`ifdef VRAM_SCHED_ERR_EN
    logic              r_err;
    logic              r_pending;
    logic              r_we_d;
    logic [ADDR_W-1:0] r_addr_d;
    logic              w_err_set;

    // r_pending marks a request that was seen in IDLE but not yet granted.
    assign w_err_set = (r_pending && !cpu_req) ||
                       ((r_state == ST_ACCESS) &&
                        (!cpu_req || (cpu_addr != r_addr_d) || (cpu_we != r_we_d)));

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            r_err     <= 1'b0;
            r_pending <= 1'b0;
            r_we_d    <= 1'b0;
            r_addr_d  <= '0;
        end else begin
            r_pending <= (r_state == ST_IDLE) && cpu_req && !w_grant;
            r_we_d    <= cpu_we;
            r_addr_d  <= cpu_addr;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cpu_err = r_err;
`endif

endmodule

// File: tb/tb_vram_scheduler.sv
// Bench for vram_scheduler: transaction-level CPU/video model with a synchronous RAM.
module tb_vram_scheduler;

    logic       clk;
    logic       n_clr;
    logic       pix_en;
    logic       hblank;
    logic [9:0] tile_addr;
    logic       cpu_req;
    logic       cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic       cpu_wait;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] tile_code;
    logic       sr_load_n;
`ifdef VRAM_SCHED_ERR_EN
    logic       cpu_err;
`endif

    vram_scheduler #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk       (clk),
        .n_clr     (n_clr),
        .pix_en    (pix_en),
        .hblank    (hblank),
        .tile_addr (tile_addr),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_wait  (cpu_wait),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .tile_code (tile_code),
        .sr_load_n (sr_load_n)
`ifdef VRAM_SCHED_ERR_EN
        ,
        .cpu_err   (cpu_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct packed {
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic [7:0] mem_ref [0:1023];
    txn_t       q[$];
    txn_t       cur;
    bit         active, granted, rst_on_access, pix_rand;
    int         cyc, ph_m, grant_cyc, last_pix, loads, we_pulses, n, req_cyc;
    int         ph_at [0:4095];
    int         ack_q[$];
    logic [7:0] tile_m, rdata_m, last_rd, old_v;
    logic [9:0] prev_tile;
    int         errors, checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk: drive CPU agent and pixel enable, check outputs, then advance the model.
    task automatic cycle();
        bit acc, ack, ld;
        logic [7:0] exp_rd;
        if (!active && q.size() > 0) begin
            cur = q.pop_front();
            active = 1'b1;
            granted = 1'b0;
        end
        cpu_req = active;
        if (active) begin
            cpu_we = cur.we;
            cpu_addr = cur.addr;
            cpu_wdata = cur.wdata;
        end
        pix_en = (cyc - last_pix >= 2) && (!pix_rand || ($urandom_range(0, 1) == 1));
        if (pix_en) last_pix = cyc;
        acc = active && granted && (cyc == grant_cyc + 1);
        ack = active && granted && (cyc == grant_cyc + 2);
        if (rst_on_access && acc) n_clr = 1'b0;
        #1;
        ld = n_clr && pix_en && !hblank && (ph_m == 7);
        chk("sr_load_n", 32'(sr_load_n), 32'(!ld));
        if (!sr_load_n) loads++;
        chk("cpu_ack", 32'(cpu_ack), 32'(ack));
        chk("cpu_wait", 32'(cpu_wait), 32'(cpu_req && !ack));
        if (acc) begin
            chk("ram_addr_cpu", 32'(ram_addr), 32'(cur.addr));
            chk("ram_we_cpu", 32'(ram_we), 32'(cur.we && n_clr));
            if (cur.we && n_clr) chk("ram_wdata", 32'(ram_wdata), 32'(cur.wdata));
        end else begin
            chk("ram_addr_vid", 32'(ram_addr), 32'(tile_addr));
            chk("ram_we_idle", 32'(ram_we), 32'(0));
        end
        if (ram_we) we_pulses++;
        exp_rd = (ack && !cur.we) ? mem_ref[cur.addr] : rdata_m;
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
        chk("tile_code", 32'(tile_code), 32'(tile_m));
        if (cpu_ack) ack_q.push_back(cyc);
        if (ack && !cur.we) last_rd = cpu_rdata;
        ph_at[cyc & 4095] = ph_m;
        @(posedge clk);
        if (!n_clr) begin
            ph_m = 0;
            tile_m = 8'h00;
            rdata_m = 8'h00;
            active = 1'b0;
            granted = 1'b0;
        end else begin
            if (ph_m == 6 && pix_en) tile_m = mem_ref[prev_tile];
            if (acc && cur.we) mem_ref[cur.addr] = cur.wdata;
            if (ack) begin
                if (!cur.we) rdata_m = mem_ref[cur.addr];
                active = 1'b0;
            end
            if (active && !granted && (hblank || ph_m inside {0, 1, 2, 3, 7})) begin
                granted = 1'b1;
                grant_cyc = cyc;
            end
            ph_m = hblank ? 0 : (pix_en ? (ph_m + 1) % 8 : ph_m);
        end
        prev_tile = tile_addr;
        cyc++;
        #1;
    endtask

    task automatic run_until_idle(input int max_cyc);
        int k;
        k = 0;
        while ((active || q.size() > 0) && k < max_cyc) begin
            cycle();
            k++;
        end
        chk("txn_done", 32'(active || q.size() > 0), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; ph_m = 0; last_pix = -10;
        active = 0; granted = 0; rst_on_access = 0; pix_rand = 0;
        tile_m = 8'h00; rdata_m = 8'h00; last_rd = 8'h00;
        n_clr = 0; pix_en = 0; hblank = 0; tile_addr = 10'h123; prev_tile = 10'h123;
        cpu_req = 0; cpu_we = 0; cpu_addr = 10'h000; cpu_wdata = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 8'($urandom);
            mem_ref[i] = ram[i];
        end
        ram[10'h123] = 8'hC3; mem_ref[10'h123] = 8'hC3;
        ram[10'h200] = 8'h3C; mem_ref[10'h200] = 8'h3C;

        // Reset
        @(posedge clk); #1;
        repeat (3) cycle();
        chk("rst_tile_code", 32'(tile_code), 32'(0));
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        n_clr = 1;

        // Steady video fetch: one load per 16 clks and tile word from 0x123
        loads = 0;
        repeat (64) cycle();
        chk("load_count", 32'(loads), 32'(4));
        chk("tile_0x123", 32'(tile_code), 32'(8'hC3));

        // CPU write at phase 1, then readback
        n = 0;
        while (ph_m != 1 && n < 40) begin cycle(); n++; end
        ack_q.delete(); we_pulses = 0; req_cyc = cyc;
        q.push_back('{we: 1'b1, addr: 10'h010, wdata: 8'h5A});
        run_until_idle(20);
        chk("wr_latency", 32'(ack_q.size() > 0 ? ack_q[0] - req_cyc : -1), 32'(2));
        chk("wr_we_pulses", 32'(we_pulses), 32'(1));
        chk("ram_0x010", 32'(ram[10'h010]), 32'(8'h5A));
        q.push_back('{we: 1'b0, addr: 10'h010, wdata: 8'h00});
        run_until_idle(20);
        chk("readback_5A", 32'(last_rd), 32'(8'h5A));

        // Request at phase 4 waits out the video slot and is granted at phase 7
        n = 0;
        while (ph_m != 4 && n < 40) begin cycle(); n++; end
        ack_q.delete();
        q.push_back('{we: 1'b0, addr: 10'h123, wdata: 8'h00});
        run_until_idle(30);
        chk("grant_phase", 32'(ack_q.size() > 0 ? ph_at[(ack_q[0] - 2) & 4095] : -1), 32'(7));
        repeat (20) cycle();
        chk("tile_after_wait", 32'(tile_code), 32'(8'hC3));

        // Horizontal blank with back-to-back reads
        hblank = 1; loads = 0; ack_q.delete();
        for (int i = 0; i < 6; i++) q.push_back('{we: 1'b0, addr: 10'($urandom), wdata: 8'h00});
        run_until_idle(40);
        chk("hb_ack_count", 32'(ack_q.size()), 32'(6));
        for (int i = 1; i < ack_q.size(); i++) chk("hb_ack_period", 32'(ack_q[i] - ack_q[i-1]), 32'(3));
        chk("hb_no_load", 32'(loads), 32'(0));
        hblank = 0;

        // Random traffic with random pix_en, hblank and tile_addr
        pix_rand = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) hblank = ~hblank;
            if ($urandom_range(0, 29) == 0) tile_addr = 10'($urandom);
            if (q.size() == 0 && $urandom_range(0, 3) == 0)
                q.push_back('{we: 1'($urandom), addr: 10'($urandom), wdata: 8'($urandom)});
            cycle();
        end
        hblank = 0; pix_rand = 0;
        run_until_idle(40);

        // Reset during a write access
        old_v = mem_ref[10'h200]; ack_q.delete();
        q.push_back('{we: 1'b1, addr: 10'h200, wdata: ~old_v});
        rst_on_access = 1;
        n = 0;
        while ((active || q.size() > 0) && n < 30) begin cycle(); n++; end
        rst_on_access = 0;
        chk("rst_no_ack", 32'(ack_q.size()), 32'(0));
        chk("rst_ram_kept", 32'(ram[10'h200]), 32'(old_v));
        chk("rst_out_tile", 32'(tile_code), 32'(0));
        chk("rst_out_rdata", 32'(cpu_rdata), 32'(0));
        chk("rst_out_ack", 32'(cpu_ack), 32'(0));
        chk("rst_out_load", 32'(sr_load_n), 32'(1));
        chk("rst_out_we", 32'(ram_we), 32'(0));
        cycle();
        n_clr = 1;
        q.push_back('{we: 1'b0, addr: 10'h200, wdata: 8'h00});
        run_until_idle(30);
        chk("rst_readback", 32'(last_rd), 32'(old_v));

`ifdef VRAM_SCHED_ERR_EN
        // Abandoned request while waiting sets the sticky error
        n = 0;
        while (ph_m != 4 && n < 40) begin cycle(); n++; end
        chk("err_clear", 32'(cpu_err), 32'(0));
        q.push_back('{we: 1'b0, addr: 10'h010, wdata: 8'h00});
        cycle();
        active = 0; granted = 0;
        cycle();
        chk("err_set", 32'(cpu_err), 32'(1));
        repeat (8) cycle();
        chk("err_sticky", 32'(cpu_err), 32'(1));
        n_clr = 0;
        cycle();
        chk("err_reset", 32'(cpu_err), 32'(0));
        n_clr = 1;
        cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
